// File: rtl/adpcm_rom_arb_if.sv
// Signal bundle for adpcm_rom_arb: the ADPCM-A and ADPCM-B sample buses plus the shared ROM port.
// The master modport belongs to the sound chip and ROM side. The slave modport belongs to the arbiter.
interface adpcm_rom_arb_if;
  logic [7:0]  sdrad_in;
  logic [1:0]  sdra_l;
  logic [3:0]  sdra_u;
  logic        sdrmpx;
  logic        n_sdroe;
  logic [7:0]  sdrad_out;
  logic        sdrad_oe;
  logic [7:0]  sdpad_in;
  logic [3:0]  sdpa;
  logic        sdpmpx;
  logic        n_sdpoe;
  logic [7:0]  sdpad_out;
  logic        sdpad_oe;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  modport master (
    output sdrad_in, sdra_l, sdra_u, sdrmpx, n_sdroe,
    output sdpad_in, sdpa, sdpmpx, n_sdpoe,
    output mem_ack, mem_data,
    input  sdrad_out, sdrad_oe, sdpad_out, sdpad_oe, mem_req, mem_addr
  );

  modport slave (
    input  sdrad_in, sdra_l, sdra_u, sdrmpx, n_sdroe,
    input  sdpad_in, sdpa, sdpmpx, n_sdpoe,
    input  mem_ack, mem_data,
    output sdrad_out, sdrad_oe, sdpad_out, sdpad_oe, mem_req, mem_addr
  );
endinterface

// File: rtl/adpcm_rom_arb.sv
// Shares one ROM port between the ADPCM-A and ADPCM-B sample fetch buses.
// Defining ARB_RR_EN selects round-robin arbitration. Otherwise ADPCM-A always has priority.
module adpcm_rom_arb #(
  parameter int MEM_LAT_MAX = 255
) (
  input logic            i_clk_24m,
  input logic            i_reset,
  adpcm_rom_arb_if.slave bus
);
  localparam int LAT_W = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_A = 2'd1, BUSY_B = 2'd2} state_t;

  state_t           r_state;
  logic             r_mpx_a_q, r_oe_a_q, r_mpx_b_q, r_oe_b_q;
  logic [23:0]      r_ptr_a, r_ptr_b, r_paddr_a, r_paddr_b;
  logic             r_pend_a, r_pend_b, r_live_a, r_live_b, r_valid_a, r_valid_b;
  logic [7:0]       r_data_a, r_data_b;
  logic             r_oe_a, r_oe_b, r_mem_req;
  logic [24:0]      r_mem_addr;
  logic [LAT_W-1:0] r_wd_cnt;

  logic w_mpx_a_rise, w_mpx_a_fall, w_oe_a_rise, w_oe_a_fall;
  logic w_mpx_b_rise, w_mpx_b_fall, w_oe_b_rise, w_oe_b_fall;
  logic w_idle, w_pick_a, w_grant_a, w_grant_b, w_wd_exp, w_done, w_done_a, w_done_b;
  logic [7:0] w_fill;

  assign w_mpx_a_rise = bus.sdrmpx & ~r_mpx_a_q;
  assign w_mpx_a_fall = ~bus.sdrmpx & r_mpx_a_q;
  assign w_oe_a_rise  = bus.n_sdroe & ~r_oe_a_q;
  assign w_oe_a_fall  = ~bus.n_sdroe & r_oe_a_q;
  assign w_mpx_b_rise = bus.sdpmpx & ~r_mpx_b_q;
  assign w_mpx_b_fall = ~bus.sdpmpx & r_mpx_b_q;
  assign w_oe_b_rise  = bus.n_sdpoe & ~r_oe_b_q;
  assign w_oe_b_fall  = ~bus.n_sdpoe & r_oe_b_q;

`ifdef ARB_RR_EN
  // r_last_b remembers which channel won the most recent contended grant.
  logic r_last_b;
  assign w_pick_a = ~r_pend_b | r_last_b;
`else
  assign w_pick_a = 1'b1;
`endif

  assign w_idle    = (r_state == IDLE);
  assign w_grant_a = w_idle & r_pend_a & w_pick_a;
  assign w_grant_b = w_idle & r_pend_b & ~w_grant_a;
  assign w_wd_exp  = (r_wd_cnt == LAT_W'(MEM_LAT_MAX - 1));
  assign w_done    = ~w_idle & (bus.mem_ack | w_wd_exp);
  assign w_done_a  = w_done & (r_state == BUSY_A);
  assign w_done_b  = w_done & (r_state == BUSY_B);
  assign w_fill    = bus.mem_ack ? bus.mem_data : 8'hFF;

  always_ff @(posedge i_clk_24m) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_mpx_a_q  <= 1'b1;
      r_oe_a_q   <= 1'b1;
      r_mpx_b_q  <= 1'b1;
      r_oe_b_q   <= 1'b1;
      r_ptr_a    <= 24'd0;
      r_ptr_b    <= 24'd0;
      r_paddr_a  <= 24'd0;
      r_paddr_b  <= 24'd0;
      r_pend_a   <= 1'b0;
      r_pend_b   <= 1'b0;
      r_live_a   <= 1'b0;
      r_live_b   <= 1'b0;
      r_valid_a  <= 1'b0;
      r_valid_b  <= 1'b0;
      r_data_a   <= 8'd0;
      r_data_b   <= 8'd0;
      r_oe_a     <= 1'b0;
      r_oe_b     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 25'd0;
      r_wd_cnt   <= '0;
`ifdef ARB_RR_EN
      r_last_b   <= 1'b1;
`endif
    end else begin
      r_mpx_a_q <= bus.sdrmpx;
      r_oe_a_q  <= bus.n_sdroe;
      r_mpx_b_q <= bus.sdpmpx;
      r_oe_b_q  <= bus.n_sdpoe;

      if (w_mpx_a_rise)      r_ptr_a[9:0]   <= {bus.sdra_l, bus.sdrad_in};
      else if (w_mpx_a_fall) r_ptr_a[23:10] <= {bus.sdra_u, bus.sdra_l, bus.sdrad_in};
      else if (w_oe_a_rise)  r_ptr_a        <= r_ptr_a + 24'd1;

      if (w_mpx_b_rise)      r_ptr_b[11:0]  <= {bus.sdpa, bus.sdpad_in};
      else if (w_mpx_b_fall) r_ptr_b[23:12] <= {bus.sdpa, bus.sdpad_in};
      else if (w_oe_b_rise)  r_ptr_b        <= r_ptr_b + 24'd1;

      // A new OE fall retargets any queued request, so a channel never has more than one request waiting.
      if (w_oe_a_fall) begin
        r_pend_a  <= 1'b1;
        r_paddr_a <= r_ptr_a;
      end else if (w_grant_a) begin
        r_pend_a  <= 1'b0;
      end
      if (w_oe_b_fall) begin
        r_pend_b  <= 1'b1;
        r_paddr_b <= r_ptr_b;
      end else if (w_grant_b) begin
        r_pend_b  <= 1'b0;
      end

      // A fetch whose OE has already risen, or that a newer fall has superseded, completes without delivering data.
      if (w_oe_a_rise)    r_live_a <= 1'b0;
      else if (w_grant_a) r_live_a <= 1'b1;
      if (w_oe_b_rise)    r_live_b <= 1'b0;
      else if (w_grant_b) r_live_b <= 1'b1;

      if (w_oe_a_fall | w_oe_a_rise) begin
        r_valid_a <= 1'b0;
      end else if (w_done_a & r_live_a & ~r_pend_a) begin
        r_valid_a <= 1'b1;
        r_data_a  <= w_fill;
      end
      if (w_oe_b_fall | w_oe_b_rise) begin
        r_valid_b <= 1'b0;
      end else if (w_done_b & r_live_b & ~r_pend_b) begin
        r_valid_b <= 1'b1;
        r_data_b  <= w_fill;
      end

      r_oe_a <= r_valid_a & ~r_oe_a_q;
      r_oe_b <= r_valid_b & ~r_oe_b_q;

      case (r_state)
        IDLE: begin
          r_wd_cnt <= '0;
          if (w_grant_a) begin
            r_state    <= BUSY_A;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {1'b0, r_paddr_a};
`ifdef ARB_RR_EN
            if (r_pend_b) r_last_b <= 1'b0;
`endif
          end else if (w_grant_b) begin
            r_state    <= BUSY_B;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {1'b1, r_paddr_b};
`ifdef ARB_RR_EN
            if (r_pend_a) r_last_b <= 1'b1;
`endif
          end
        end
        BUSY_A, BUSY_B: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end else begin
            r_wd_cnt  <= r_wd_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sdrad_out = r_data_a;
  assign bus.sdrad_oe  = r_oe_a;
  assign bus.sdpad_out = r_data_b;
  assign bus.sdpad_oe  = r_oe_b;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
endmodule
